// File: rtl/pia_ctrl_bank.sv
// Control-register bank for a 6520-style peripheral interface: one control
// register per channel, CX1/CX2 edge flags, CX2 output modes and per-channel IRQ.
module pia_ctrl_bank #(
   parameter int NCH         = 2,
   parameter int SYNC_STAGES = 2,
   localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cs,
   input  logic               rw,
   input  logic               rs,
   input  logic [CHW-1:0]     chsel,
   input  logic [7:0]         datain,
   output logic [7:0]         dataout,
   output logic               dout_en,
   input  logic [NCH-1:0]     cx1,
   input  logic [NCH-1:0]     cx2_in,
   output logic [NCH-1:0]     cx2_out,
   output logic [NCH-1:0]     cx2_oe,
   output logic [NCH*8-1:0]   ctrlbits,
   output logic [NCH-1:0]     irq
);

   typedef enum logic [1:0] {
      MODE_INPUT,
      MODE_HANDSHAKE,
      MODE_PULSE,
      MODE_MANUAL
   } cx2_mode_t;

   function automatic cx2_mode_t mode_of(input logic [5:0] c);
      if (!c[5])     return MODE_INPUT;
      else if (c[4]) return MODE_MANUAL;
      else if (c[3]) return MODE_PULSE;
      else           return MODE_HANDSHAKE;
   endfunction

   // One extra bit so the range check is not trivially constant when NCH is a power of two.
   localparam logic [CHW:0] NCH_W = (CHW+1)'(NCH);

   logic             ch_ok;
   logic             ctrl_wr;
   logic             ctrl_rd;
   logic             data_rd;

   logic [5:0]       ctrl     [NCH];
   logic [5:0]       ctrl_nxt [NCH];
   logic [NCH-1:0]   f7, f7_nxt;
   logic [NCH-1:0]   f6, f6_nxt;
   logic [NCH-1:0]   cx2_q, cx2_nxt;

   logic [NCH-1:0]   sync1 [SYNC_STAGES];
   logic [NCH-1:0]   sync2 [SYNC_STAGES];
   logic [NCH-1:0]   hist1, hist2;

   logic [NCH-1:0]   wr_hit, rd_hit, edge1, edge2, mode_enter;
   logic [7:0]       rd_sel;

   logic             unused_datain;
   assign unused_datain = ^datain[7:6];

   assign ch_ok   = {1'b0, chsel} < NCH_W;
   assign ctrl_wr = cs & ~rw &  rs & ch_ok;
   assign ctrl_rd = cs &  rw &  rs & ch_ok;
   assign data_rd = cs &  rw & ~rs & ch_ok;

   // Pin synchronisers plus one history flop per line; idle-high after reset
   // so no edge appears until a pin genuinely moves.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync1[i] <= '1;
            sync2[i] <= '1;
         end
         hist1 <= '1;
         hist2 <= '1;
      end else begin
         // NOTE: non-blocking assignments let every stage sample its predecessor's old value, forming a true shift chain.
         sync1[0] <= cx1;
         sync2[0] <= cx2_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync1[i] <= sync1[i-1];
            sync2[i] <= sync2[i-1];
         end
         hist1 <= sync1[SYNC_STAGES-1];
         hist2 <= sync2[SYNC_STAGES-1];
      end
   end

   // Per-channel decode: address hits, active edges, and entry into a new CX2 mode.
   always_comb begin
      wr_hit     = '0;
      rd_hit     = '0;
      edge1      = '0;
      edge2      = '0;
      mode_enter = '0;
      for (int n = 0; n < NCH; n++) begin
         wr_hit[n] = ctrl_wr && (chsel == CHW'(n));
         rd_hit[n] = data_rd && (chsel == CHW'(n));
         edge1[n]  = ctrl[n][1] ? ( sync1[SYNC_STAGES-1][n] & ~hist1[n])
                                : (~sync1[SYNC_STAGES-1][n] &  hist1[n]);
         edge2[n]  = ctrl[n][4] ? ( sync2[SYNC_STAGES-1][n] & ~hist2[n])
                                : (~sync2[SYNC_STAGES-1][n] &  hist2[n]);
         mode_enter[n] = wr_hit[n] && (mode_of(datain[5:0]) != mode_of(ctrl[n]));
      end
   end

   // NOTE: every always_comb output gets a default before any branch, so no path can leave it unassigned and infer a latch.
   always_comb begin
      ctrl_nxt = ctrl;
      f7_nxt   = f7;
      f6_nxt   = f6;
      cx2_nxt  = cx2_q;
      for (int n = 0; n < NCH; n++) begin
         if (wr_hit[n]) ctrl_nxt[n] = datain[5:0];

         // Set beats the data-read clear.
         f7_nxt[n] = edge1[n] | (f7[n] & ~rd_hit[n]);

         if (wr_hit[n] && datain[5])        f6_nxt[n] = 1'b0;
         else if (edge2[n] && !ctrl[n][5])  f6_nxt[n] = 1'b1;
         else if (rd_hit[n])                f6_nxt[n] = 1'b0;

         unique case (mode_of(ctrl_nxt[n]))
            MODE_INPUT:  cx2_nxt[n] = 1'b1;
            MODE_MANUAL: cx2_nxt[n] = ctrl_nxt[n][3];
            MODE_PULSE:  cx2_nxt[n] = mode_enter[n] | ~rd_hit[n];
            MODE_HANDSHAKE: begin
               // A read in the same cycle as the CX1 edge keeps the line low.
               if (mode_enter[n])  cx2_nxt[n] = 1'b1;
               else if (rd_hit[n]) cx2_nxt[n] = 1'b0;
               else if (edge1[n])  cx2_nxt[n] = 1'b1;
            end
            default: cx2_nxt[n] = 1'b1;
         endcase
      end
   end

   // NOTE: the register array is small and architecturally visible, so every entry is reset rather than left to power-up.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int n = 0; n < NCH; n++) ctrl[n] <= '0;
         f7    <= '0;
         f6    <= '0;
         cx2_q <= '1;
      end else begin
         ctrl  <= ctrl_nxt;
         f7    <= f7_nxt;
         f6    <= f6_nxt;
         cx2_q <= cx2_nxt;
      end
   end

   always_comb begin
      ctrlbits = '0;
      irq      = '0;
      cx2_oe   = '0;
      rd_sel   = 8'h00;
      for (int n = 0; n < NCH; n++) begin
         ctrlbits[8*n +: 8] = {f7[n], f6[n] & ~ctrl[n][5], ctrl[n]};
         irq[n]    = (f7[n] & ctrl[n][0]) | (f6[n] & ctrl[n][3] & ~ctrl[n][5]);
         cx2_oe[n] = ctrl[n][5];
         if (chsel == CHW'(n)) rd_sel = {f7[n], f6[n] & ~ctrl[n][5], ctrl[n]};
      end
   end

   assign dout_en = ctrl_rd;
   assign dataout = ctrl_rd ? rd_sel : 8'h00;
   assign cx2_out = cx2_q;

endmodule

// File: tb/tb_pia_ctrl_bank.sv
// Directed bench for pia_ctrl_bank (2 channels, 2 sync stages): register access,
// CX1/CX2 flags, handshake/pulse/manual CX2 and reset behaviour.
module tb_pia_ctrl_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs, rw, rs;
   logic [0:0]  chsel;
   logic [7:0]  datain;
   logic [7:0]  dataout;
   logic        dout_en;
   logic [1:0]  cx1, cx2_in, cx2_out, cx2_oe, irq;
   logic [15:0] ctrlbits;

   int checks   = 0;
   int failures = 0;

   logic [7:0] rv;
   logic       re;

   pia_ctrl_bank #(.NCH(2), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .cs       (cs),
      .rw       (rw),
      .rs       (rs),
      .chsel    (chsel),
      .datain   (datain),
      .dataout  (dataout),
      .dout_en  (dout_en),
      .cx1      (cx1),
      .cx2_in   (cx2_in),
      .cx2_out  (cx2_out),
      .cx2_oe   (cx2_oe),
      .ctrlbits (ctrlbits),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ctrl_write(input logic ch, input logic [7:0] v);
      cs = 1'b1; rw = 1'b0; rs = 1'b1; chsel = ch; datain = v;
      tick();
      cs = 1'b0; rw = 1'b1;
   endtask

   task automatic data_read(input logic ch);
      cs = 1'b1; rw = 1'b1; rs = 1'b0; chsel = ch;
      tick();
      cs = 1'b0;
   endtask

   task automatic ctrl_read(input logic ch, output logic [7:0] v, output logic en);
      cs = 1'b1; rw = 1'b1; rs = 1'b1; chsel = ch;
      #1;
      v  = dataout;
      en = dout_en;
      cs = 1'b0;
   endtask

   task automatic test_reset();
      cs = 1'b0; rw = 1'b1; rs = 1'b0; chsel = 1'b0; datain = 8'h00;
      cx1 = 2'b11; cx2_in = 2'b11;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();
      checks++; if (ctrlbits !== 16'h0000) begin failures++; $display("FAIL reset_ctrlbits got=%h exp=%h", ctrlbits, 16'h0000); end
      checks++; if (irq !== 2'b00)         begin failures++; $display("FAIL reset_irq got=%b exp=%b", irq, 2'b00); end
      checks++; if (cx2_out !== 2'b11)     begin failures++; $display("FAIL reset_cx2_out got=%b exp=%b", cx2_out, 2'b11); end
      checks++; if (cx2_oe !== 2'b00)      begin failures++; $display("FAIL reset_cx2_oe got=%b exp=%b", cx2_oe, 2'b00); end
      checks++; if (dataout !== 8'h00 || dout_en !== 1'b0) begin failures++; $display("FAIL reset_dataout got=%h/%b exp=00/0", dataout, dout_en); end
   endtask

   task automatic test_ctrl_rw();
      ctrl_write(1'b0, 8'h03);
      ctrl_write(1'b1, 8'h00);
      ctrl_read(1'b0, rv, re);
      checks++; if (rv !== 8'h03 || re !== 1'b1) begin failures++; $display("FAIL rd_ch0 got=%h/%b exp=03/1", rv, re); end
      ctrl_read(1'b1, rv, re);
      checks++; if (rv !== 8'h00) begin failures++; $display("FAIL rd_ch1 got=%h exp=00", rv); end
      checks++; if (irq !== 2'b00) begin failures++; $display("FAIL rw_irq got=%b exp=00", irq); end
      checks++; if (cx2_out !== 2'b11) begin failures++; $display("FAIL rw_cx2_out got=%b exp=11", cx2_out); end
      // Data-register access must not drive the control read bus.
      cs = 1'b1; rw = 1'b1; rs = 1'b0; chsel = 1'b0;
      #1;
      checks++; if (dout_en !== 1'b0 || dataout !== 8'h00) begin failures++; $display("FAIL data_access_bus got=%h/%b exp=00/0", dataout, dout_en); end
      cs = 1'b0;
      ctrl_write(1'b1, 8'hFF);
      ctrl_read(1'b1, rv, re);
      checks++; if (rv !== 8'h3F) begin failures++; $display("FAIL wr_ff_ch1 got=%h exp=3f", rv); end
      checks++; if (cx2_oe !== 2'b10 || cx2_out !== 2'b11) begin failures++; $display("FAIL manual_hi got=oe%b/out%b exp=oe10/out11", cx2_oe, cx2_out); end
      ctrl_write(1'b1, 8'hF0);
      checks++; if (cx2_out !== 2'b01) begin failures++; $display("FAIL manual_lo got=%b exp=01", cx2_out); end
      ctrl_write(1'b1, 8'h00);
      checks++; if (cx2_out !== 2'b11 || cx2_oe !== 2'b00) begin failures++; $display("FAIL back_to_input got=out%b/oe%b exp=out11/oe00", cx2_out, cx2_oe); end
   endtask

   task automatic test_cx1_flag();
      cx1[0] = 1'b0;
      repeat (4) tick();
      checks++; if (ctrlbits[7:0] !== 8'h03) begin failures++; $display("FAIL cx1_fall_ignored got=%h exp=03", ctrlbits[7:0]); end
      cx1[0] = 1'b1;
      tick(); tick();
      checks++; if (irq[0] !== 1'b0) begin failures++; $display("FAIL cx1_early got=%b exp=0", irq[0]); end
      tick();
      checks++; if (irq[0] !== 1'b1) begin failures++; $display("FAIL cx1_latency got=%b exp=1", irq[0]); end
      ctrl_read(1'b0, rv, re);
      checks++; if (rv !== 8'h83) begin failures++; $display("FAIL cx1_read got=%h exp=83", rv); end
      data_read(1'b0);
      checks++; if (irq[0] !== 1'b0 || ctrlbits[7] !== 1'b0) begin failures++; $display("FAIL cx1_clear got=irq%b/f7%b exp=0/0", irq[0], ctrlbits[7]); end
      cx1[0] = 1'b0;
      repeat (4) tick();
      checks++; if (ctrlbits[7:0] !== 8'h03) begin failures++; $display("FAIL cx1_fall_again got=%h exp=03", ctrlbits[7:0]); end
   endtask

   task automatic test_cx2_input();
      ctrl_write(1'b1, 8'h08);
      cx2_in[1] = 1'b0;
      repeat (3) tick();
      ctrl_read(1'b1, rv, re);
      checks++; if (rv !== 8'h48) begin failures++; $display("FAIL cx2_flag_read got=%h exp=48", rv); end
      checks++; if (irq !== 2'b10) begin failures++; $display("FAIL cx2_irq got=%b exp=10", irq); end
      ctrl_write(1'b1, 8'h38);
      ctrl_read(1'b1, rv, re);
      checks++; if (rv !== 8'h38) begin failures++; $display("FAIL cx2_b5_read got=%h exp=38", rv); end
      checks++; if (irq[1] !== 1'b0 || cx2_out[1] !== 1'b1) begin failures++; $display("FAIL cx2_b5_out got=irq%b/out%b exp=0/1", irq[1], cx2_out[1]); end
      ctrl_write(1'b1, 8'h08);
      ctrl_read(1'b1, rv, re);
      checks++; if (rv !== 8'h08) begin failures++; $display("FAIL cx2_f6_cleared got=%h exp=08", rv); end
   endtask

   task automatic test_handshake();
      ctrl_write(1'b0, 8'h22);
      checks++; if (cx2_out[0] !== 1'b1 || cx2_oe !== 2'b01) begin failures++; $display("FAIL hs_enter got=out%b/oe%b exp=1/01", cx2_out[0], cx2_oe); end
      data_read(1'b0);
      checks++; if (cx2_out[0] !== 1'b0) begin failures++; $display("FAIL hs_read_low got=%b exp=0", cx2_out[0]); end
      cx1[0] = 1'b1;
      tick(); tick();
      checks++; if (cx2_out[0] !== 1'b0) begin failures++; $display("FAIL hs_hold_low got=%b exp=0", cx2_out[0]); end
      tick();
      checks++; if (cx2_out[0] !== 1'b1 || ctrlbits[7] !== 1'b1) begin failures++; $display("FAIL hs_release got=out%b/f7%b exp=1/1", cx2_out[0], ctrlbits[7]); end
      checks++; if (irq[0] !== 1'b0) begin failures++; $display("FAIL hs_irq_masked got=%b exp=0", irq[0]); end
      cx1[0] = 1'b0;
      repeat (3) tick();
      data_read(1'b0);
      checks++; if (cx2_out[0] !== 1'b0 || ctrlbits[7] !== 1'b0) begin failures++; $display("FAIL hs_rearm got=out%b/f7%b exp=0/0", cx2_out[0], ctrlbits[7]); end
      // Rising edge is detected in the same cycle as this data read.
      cx1[0] = 1'b1;
      tick(); tick();
      data_read(1'b0);
      checks++; if (cx2_out[0] !== 1'b0) begin failures++; $display("FAIL hs_read_wins got=%b exp=0", cx2_out[0]); end
      checks++; if (ctrlbits[7] !== 1'b1) begin failures++; $display("FAIL set_beats_clear got=%b exp=1", ctrlbits[7]); end
      tick();
      checks++; if (cx2_out[0] !== 1'b0) begin failures++; $display("FAIL hs_stays_low got=%b exp=0", cx2_out[0]); end
   endtask

   task automatic test_reset_mid();
      cx2_in = 2'b11;
      repeat (3) tick();
      reset = 1'b1;
      cs = 1'b1; rw = 1'b0; rs = 1'b1; chsel = 1'b1; datain = 8'h3F;
      tick();
      reset = 1'b0; cs = 1'b0; rw = 1'b1;
      checks++; if (ctrlbits !== 16'h0000) begin failures++; $display("FAIL midrst_ctrl got=%h exp=0000", ctrlbits); end
      checks++; if (cx2_out !== 2'b11 || irq !== 2'b00 || cx2_oe !== 2'b00) begin failures++; $display("FAIL midrst_out got=out%b/irq%b/oe%b exp=11/00/00", cx2_out, irq, cx2_oe); end
      repeat (3) tick();
      checks++; if (ctrlbits !== 16'h0000) begin failures++; $display("FAIL midrst_no_edge got=%h exp=0000", ctrlbits); end
   endtask

   task automatic test_back_to_back();
      ctrl_write(1'b0, 8'h28);
      checks++; if (cx2_out !== 2'b11) begin failures++; $display("FAIL pulse_enter got=%b exp=11", cx2_out); end
      data_read(1'b0);
      checks++; if (cx2_out !== 2'b10) begin failures++; $display("FAIL pulse_low got=%b exp=10", cx2_out); end
      tick();
      checks++; if (cx2_out !== 2'b11) begin failures++; $display("FAIL pulse_one_clk got=%b exp=11", cx2_out); end
      cs = 1'b1; rw = 1'b1; rs = 1'b0; chsel = 1'b0;
      tick();
      checks++; if (cx2_out !== 2'b10) begin failures++; $display("FAIL b2b_first got=%b exp=10", cx2_out); end
      tick();
      cs = 1'b0;
      checks++; if (cx2_out !== 2'b10) begin failures++; $display("FAIL b2b_second got=%b exp=10", cx2_out); end
      tick();
      checks++; if (cx2_out !== 2'b11) begin failures++; $display("FAIL b2b_release got=%b exp=11", cx2_out); end
   endtask

   initial begin
      test_reset();
      test_ctrl_rw();
      test_cx1_flag();
      test_cx2_input();
      test_handshake();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
